ft232h_rx: RTL and testbench
============================

Name: ft232h_rx

Overview:
- Receive (host-to-FPGA) side of the FT232H 245 synchronous FIFO interface.
- Drives the FTDI read strobes, captures bytes from ADBUS into a small first-word-fall-through buffer, and presents them as an 8-bit AXI-Stream source (m_axis).
- Sits in the ftdi_clk domain beside the existing transmit path.
- An external arbiter grants the shared ADBUS to this block through rx_enable / rx_active.

Parameters:
- DEPTH, 16, buffer depth in bytes; power of 2, >= 4.
- HEADROOM, 4, minimum free entries required to start or continue a read burst; 2 <= HEADROOM < DEPTH.

Ports:
- ftdi_clk  input  1  60 MHz FTDI clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- ftdi_rxf_n  input  1  low = FTDI has data for the FPGA; synchronous to ftdi_clk.
- ftdi_adbus  input  8  FTDI data bus, input side; the top level handles tri-state.
- ftdi_rd_n  output  1  read strobe, active low.
- ftdi_oe_n  output  1  FTDI output enable, active low. The top level must not drive ADBUS while this is low.
- rx_enable  input  1  arbiter permission to start a new burst.
- rx_active  output  1  high while the block owns ADBUS (state != IDLE).
- m_axis_tdata  output  8  head byte of the buffer.
- m_axis_tvalid  output  1  buffer not empty.
- m_axis_tready  input  1  downstream accept.
- rx_overflow  output  1  sticky error flag: a byte arrived while the buffer was full.

Behaviour:
- Clock and reset:
  - One clock, ftdi_clk. All state is registered on its rising edge.
  - rst_n is asynchronous and active-low.
- Reset values:
  - ftdi_rd_n = 1, ftdi_oe_n = 1, rx_active = 0.
  - State = IDLE, buffer count = 0, m_axis_tvalid = 0, rx_overflow = 0.
  - m_axis_tdata is don't-care while tvalid = 0.
- Free-space definition: free = DEPTH - count, using the registered count.
- FSM states: IDLE, OE, READ, RELEASE.
  - IDLE: rd_n = 1, oe_n = 1. Go to OE when ftdi_rxf_n == 0, rx_enable == 1 and free >= HEADROOM.
  - OE: oe_n = 0, rd_n = 1. Lasts exactly 1 cycle (bus turnaround), then go to READ.
  - READ: oe_n = 0, rd_n = 0. Stay while ftdi_rxf_n == 0 and free > HEADROOM. Otherwise go to RELEASE. rx_enable dropping does not end a burst.
  - RELEASE: rd_n = 1, oe_n = 0 for 1 cycle, then go to IDLE, where oe_n = 1.
  - All strobes are registered outputs; no combinational path from inputs to ftdi_rd_n or ftdi_oe_n.
- Capture rule:
  - At a rising edge where registered ftdi_rd_n == 0 and sampled ftdi_rxf_n == 0, ftdi_adbus is one transferred byte and is written to the buffer tail.
  - The first capture happens at the first edge after the OE->READ transition.
  - One byte may be captured on the edge that leaves READ; HEADROOM >= 2 guarantees space for it.
- Buffer:
  - First-word-fall-through. m_axis_tdata = head entry; m_axis_tvalid = (count != 0).
  - An AXIS transfer happens on tvalid && tready and pops the head.
  - Simultaneous capture and pop in the same cycle leaves count unchanged; data order is preserved.
  - Read and write pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits wide.
- Overflow:
  - A capture while count == DEPTH with no simultaneous pop drops the byte, sets rx_overflow and leaves the buffer unchanged.
  - rx_overflow clears only on reset. It is unreachable under correct parameters and exists for verification.
- Throughput: steady state with tready = 1 is 1 byte per cycle. Burst overhead is 3 idle bus cycles (OE + RELEASE + IDLE).
- Reset mid-operation:
  - Strobes return high immediately (asynchronous).
  - Buffered and in-flight bytes are discarded.
- AXIS rule: tdata and tvalid must not change while tvalid = 1 and tready = 0, except that tdata follows the head after a pop.

Test Plan:
- Single byte: rxf_n low for 1 read cycle with 0xA5, tready = 1.
  -> Sequence oe_n low, next cycle rd_n low. Exactly one AXIS beat 0xA5. Then RELEASE and IDLE with oe_n = 1.
- Burst: 40 bytes 0x00..0x27 back-to-back, tready = 1.
  -> rd_n stays low for 40 capture cycles. 40 beats in order. rx_overflow = 0.
- Backpressure: 40 bytes with tready = 0 (DEPTH = 16, HEADROOM = 4).
  -> Burst ends with count <= 16. rx_active drops. Releasing tready later yields 0x00..0x27 in order across multiple bursts. No overflow.
- rxf_n rises mid-burst after byte 5, then returns low.
  -> Exactly 5 bytes captured. RELEASE then IDLE. A new burst resumes with byte 6. No duplicates.
- rx_enable = 0 with rxf_n low.
  -> Block stays in IDLE with oe_n = 1 and rx_active = 0.
  -> Dropping rx_enable mid-burst does not terminate that burst.
- rst_n pulsed low during READ with 3 bytes buffered.
  -> rd_n and oe_n go high without waiting for a clock edge. tvalid = 0 and count = 0 after reset.

Source files
------------

// File: rtl/ft232h_rx_if.sv
// AXI-Stream byte channel carrying received FTDI bytes to the downstream consumer.
`timescale 1ns/1ps
interface ft232h_rx_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/ft232h_rx.sv
// FT232H 245 synchronous FIFO receive path: drives the FTDI read strobes,
// captures ADBUS bytes into a first-word-fall-through buffer and presents
// them on an 8-bit AXI-Stream source.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | bus not owned; strobes high; wait for data, grant, headroom
// OE      | FTDI output enable asserted for one turnaround cycle
// READ    | rd_n low; one byte transferred per cycle while rxf_n low
// RELEASE | rd_n high, oe_n still low for one cycle before giving up bus
`timescale 1ns/1ps
module ft232h_rx #(
    parameter int DEPTH    = 16,
    parameter int HEADROOM = 4
) (
    input  logic       ftdi_clk,
    input  logic       rst_n,
    input  logic       ftdi_rxf_n,
    input  logic [7:0] ftdi_adbus,
    output logic       ftdi_rd_n,
    output logic       ftdi_oe_n,
    input  logic       rx_enable,
    output logic       rx_active,
    output logic       rx_overflow,
    ft232h_rx_if.master m_axis
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] HEAD_C = (AW+1)'(HEADROOM);

    typedef enum logic [1:0] {S_IDLE, S_OE, S_READ, S_RELEASE} state_t;

    state_t        state_q;
    logic          rd_n_q;
    logic          oe_n_q;
    logic          active_q;
    logic          overflow_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [7:0]    mem_q [DEPTH];

    logic [AW:0]   free_w;
    logic          capture_w;
    logic          pop_w;
    logic          push_w;

    assign free_w    = FULL_C - count_q;
    assign capture_w = !rd_n_q && !ftdi_rxf_n;
    assign pop_w     = (count_q != '0) && m_axis.tready;
    // When full, a same-cycle pop frees the slot the incoming byte lands in.
    assign push_w    = capture_w && ((count_q != FULL_C) || pop_w);

    assign ftdi_rd_n     = rd_n_q;
    assign ftdi_oe_n     = oe_n_q;
    assign rx_active     = active_q;
    assign rx_overflow   = overflow_q;
    assign m_axis.tvalid = (count_q != '0);
    assign m_axis.tdata  = mem_q[rd_ptr_q];

    // Bus sequencing FSM; all strobes are registered alongside the state.
    always_ff @(posedge ftdi_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rd_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            active_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!ftdi_rxf_n && rx_enable && (free_w >= HEAD_C)) begin
                        state_q  <= S_OE;
                        oe_n_q   <= 1'b0;
                        active_q <= 1'b1;
                    end
                end
                S_OE: begin
                    state_q <= S_READ;
                    rd_n_q  <= 1'b0;
                end
                S_READ: begin
                    // Leaving with free == HEADROOM still leaves room for the
                    // byte captured on this same edge.
                    if (ftdi_rxf_n || (free_w <= HEAD_C)) begin
                        state_q <= S_RELEASE;
                        rd_n_q  <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    state_q  <= S_IDLE;
                    oe_n_q   <= 1'b1;
                    active_q <= 1'b0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    rd_n_q   <= 1'b1;
                    oe_n_q   <= 1'b1;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    // Occupancy next-state from push/pop.
    always_comb begin
        count_d = count_q;
        if (push_w && !pop_w) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_w && pop_w) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Buffer pointers, occupancy and sticky overflow flag.
    always_ff @(posedge ftdi_clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push_w) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_w) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (capture_w && !push_w) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage array; contents are meaningless once count is cleared.
    always_ff @(posedge ftdi_clk) begin
        if (push_w) begin
            mem_q[wr_ptr_q] <= ftdi_adbus;
        end
    end

endmodule

// File: tb/tb_ft232h_rx.sv
// Testbench for ft232h_rx: FTDI host emulator, AXIS scoreboard monitor and
// directed scenario sequence.
`timescale 1ns/1ps
module tb_ft232h_rx;
    localparam int DEPTH    = 16;
    localparam int HEADROOM = 4;

    logic       ftdi_clk   = 1'b0;
    logic       rst_n      = 1'b0;
    logic       ftdi_rxf_n = 1'b1;
    logic [7:0] ftdi_adbus = 8'h00;
    logic       ftdi_rd_n;
    logic       ftdi_oe_n;
    logic       rx_enable  = 1'b0;
    logic       rx_active;
    logic       rx_overflow;

    ft232h_rx_if axis ();

    int checks   = 0;
    int failures = 0;
    int captured = 0;
    int bursts   = 0;
    logic [7:0] host_q [$];
    logic [7:0] exp_q  [$];

    always #8 ftdi_clk = ~ftdi_clk;

    ft232h_rx #(.DEPTH(DEPTH), .HEADROOM(HEADROOM)) dut (
        .ftdi_clk   (ftdi_clk),
        .rst_n      (rst_n),
        .ftdi_rxf_n (ftdi_rxf_n),
        .ftdi_adbus (ftdi_adbus),
        .ftdi_rd_n  (ftdi_rd_n),
        .ftdi_oe_n  (ftdi_oe_n),
        .rx_enable  (rx_enable),
        .rx_active  (rx_active),
        .rx_overflow(rx_overflow),
        .m_axis     (axis)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // FTDI host: presents host_q head on ADBUS, advances on each transfer.
    initial begin : ftdi_model
        logic rd_seen, rxf_seen;
        forever begin
            @(negedge ftdi_clk);
            rd_seen  = ftdi_rd_n;
            rxf_seen = ftdi_rxf_n;
            @(posedge ftdi_clk);
            #1;
            if (rst_n && !rd_seen && !rxf_seen && host_q.size() > 0) begin
                void'(host_q.pop_front());
                captured++;
            end
            ftdi_rxf_n = (host_q.size() == 0);
            if (host_q.size() > 0) ftdi_adbus = host_q[0];
        end
    end

    // AXIS monitor: scoreboard compare, hold rule, strobe ordering, burst count.
    initial begin : axis_monitor
        logic [7:0] held_data;
        logic       held;
        logic       prev_oe;
        held    = 1'b0;
        prev_oe = 1'b1;
        forever begin
            @(negedge ftdi_clk);
            if (!rst_n) begin
                held    = 1'b0;
                prev_oe = 1'b1;
                continue;
            end
            if (held) begin
                chk("axis_hold_valid", axis.tvalid, 1);
                chk("axis_hold_data", axis.tdata, held_data);
            end
            if (prev_oe && !ftdi_oe_n) bursts++;
            prev_oe = ftdi_oe_n;
            if (!ftdi_rd_n) chk("rd_needs_oe", ftdi_oe_n, 0);
            if (axis.tvalid === 1'b1 && axis.tready === 1'b1) begin
                chk("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("beat_data", axis.tdata, exp_q.pop_front());
            end
            held      = (axis.tvalid === 1'b1) && (axis.tready !== 1'b1);
            held_data = axis.tdata;
        end
    end

    task automatic push_bytes(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            host_q.push_back(start + 8'(i));
            exp_q.push_back(start + 8'(i));
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge ftdi_clk);
        #1;
        axis.tready = v;
    endtask

    task automatic wait_drained(input string tag);
        int n = 0;
        while (!(exp_q.size() == 0 && host_q.size() == 0 && rx_active === 1'b0 &&
                 ftdi_oe_n === 1'b1) && n < 3000) begin
            @(negedge ftdi_clk);
            n++;
        end
        chk(tag, n < 3000, 1);
    endtask

    initial begin : stimulus
        int n, b0, c0;
        axis.tready = 1'b1;

        // Reset values
        repeat (3) @(negedge ftdi_clk);
        chk("rst_rd_n", ftdi_rd_n, 1);
        chk("rst_oe_n", ftdi_oe_n, 1);
        chk("rst_active", rx_active, 0);
        chk("rst_tvalid", axis.tvalid, 0);
        chk("rst_overflow", rx_overflow, 0);
        rst_n     = 1'b1;
        rx_enable = 1'b1;
        repeat (2) @(negedge ftdi_clk);

        // Single byte: OE then READ then RELEASE then IDLE
        b0 = bursts;
        push_bytes(8'hA5, 1);
        n = 0;
        while (ftdi_oe_n !== 1'b0 && n < 50) begin
            @(negedge ftdi_clk);
            n++;
        end
        chk("t1_oe_seen", n < 50, 1);
        chk("t1_oe_rd_n", ftdi_rd_n, 1);
        chk("t1_oe_active", rx_active, 1);
        @(negedge ftdi_clk);
        chk("t1_read_rd_n", ftdi_rd_n, 0);
        chk("t1_read_oe_n", ftdi_oe_n, 0);
        @(negedge ftdi_clk);
        @(negedge ftdi_clk);
        chk("t1_rel_rd_n", ftdi_rd_n, 1);
        chk("t1_rel_oe_n", ftdi_oe_n, 0);
        @(negedge ftdi_clk);
        chk("t1_idle_oe_n", ftdi_oe_n, 1);
        chk("t1_idle_active", rx_active, 0);
        wait_drained("t1_drain");
        chk("t1_bursts", bursts - b0, 1);

        // 40-byte burst with tready high: one burst, 40 captures
        b0 = bursts;
        c0 = captured;
        push_bytes(8'h00, 40);
        wait_drained("t2_drain");
        chk("t2_bursts", bursts - b0, 1);
        chk("t2_captured", captured - c0, 40);
        chk("t2_overflow", rx_overflow, 0);

        // Backpressure: burst stops with DEPTH-HEADROOM+1 bytes buffered
        set_ready(1'b0);
        c0 = captured;
        push_bytes(8'h00, 40);
        n = 0;
        while (rx_active !== 1'b1 && n < 50) begin
            @(negedge ftdi_clk);
            n++;
        end
        chk("t3_start", n < 50, 1);
        n = 0;
        while (rx_active !== 1'b0 && n < 200) begin
            @(negedge ftdi_clk);
            n++;
        end
        chk("t3_stop", n < 200, 1);
        repeat (6) @(negedge ftdi_clk);
        chk("t3_captured", captured - c0, DEPTH - HEADROOM + 1);
        chk("t3_active", rx_active, 0);
        chk("t3_oe_n", ftdi_oe_n, 1);
        chk("t3_tvalid", axis.tvalid, 1);
        set_ready(1'b1);
        wait_drained("t3_drain");
        chk("t3_overflow", rx_overflow, 0);

        // rxf_n rises after 5 bytes, then more data arrives
        b0 = bursts;
        c0 = captured;
        push_bytes(8'h30, 5);
        wait_drained("t4_drain_a");
        chk("t4_captured", captured - c0, 5);
        chk("t4_bursts_a", bursts - b0, 1);
        push_bytes(8'h35, 6);
        wait_drained("t4_drain_b");
        chk("t4_bursts_b", bursts - b0, 2);

        // rx_enable low blocks a new burst
        @(negedge ftdi_clk);
        rx_enable = 1'b0;
        push_bytes(8'h50, 3);
        for (int i = 0; i < 10; i++) begin
            @(negedge ftdi_clk);
            chk("t5_hold_oe_n", ftdi_oe_n, 1);
            chk("t5_hold_active", rx_active, 0);
        end
        rx_enable = 1'b1;
        wait_drained("t5_drain");

        // rx_enable dropped mid-burst does not end it
        b0 = bursts;
        push_bytes(8'h60, 20);
        n = 0;
        while (ftdi_rd_n !== 1'b0 && n < 50) begin
            @(negedge ftdi_clk);
            n++;
        end
        chk("t5_read_seen", n < 50, 1);
        rx_enable = 1'b0;
        wait_drained("t5_mid_drain");
        chk("t5_mid_bursts", bursts - b0, 1);
        rx_enable = 1'b1;

        // Asynchronous reset during READ with 3 bytes buffered
        set_ready(1'b0);
        c0 = captured;
        push_bytes(8'h70, 10);
        n = 0;
        while ((captured - c0) < 3 && n < 100) begin
            @(negedge ftdi_clk);
            n++;
        end
        chk("t6_three", n < 100, 1);
        chk("t6_in_read", ftdi_rd_n, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_rd_n", ftdi_rd_n, 1);
        chk("t6_async_oe_n", ftdi_oe_n, 1);
        chk("t6_async_active", rx_active, 0);
        chk("t6_async_tvalid", axis.tvalid, 0);
        host_q.delete();
        exp_q.delete();
        repeat (2) @(negedge ftdi_clk);
        rst_n = 1'b1;
        repeat (5) @(negedge ftdi_clk);
        chk("t6_post_tvalid", axis.tvalid, 0);
        chk("t6_post_active", rx_active, 0);
        set_ready(1'b1);
        push_bytes(8'h80, 2);
        wait_drained("t6_drain");
        chk("final_overflow", rx_overflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
